// File: rtl/lsu_mem_initiator_if.sv
// Pipeline-request and memory-port bundle for lsu_mem_initiator.
// master: the initiator's view; slave: the pipeline + memory side.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [31:0]       mem_rdata;
  logic              mem_write;
  logic [31:0]       mem_wdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_grant, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_grant, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM stage and a single-port word memory.
// One byte-addressed access at a time; sub-word stores are read-modify-write,
// accesses crossing a word boundary are split into two word accesses.
// Build option MISALIGN_TRAP_EN: spanning or not naturally aligned accesses
// are answered with resp_err and no memory traffic; RD1/WR1 are not built.
module lsu_mem_initiator #(
  parameter int ADDR_W = 6
) (
  input logic                 clk,
  input logic                 rst,
  lsu_mem_initiator_if.master bus
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, RD0, WR0, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;
`endif

  state_t state_q, state_d;

  logic              st_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, w0_q, w1_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic              accept;

  // byte-enable pattern for a 1/2/4 byte access at lane 0
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // true when the highest touched byte lands in the next word
  function automatic logic spans(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] last;
    last = {1'b0, off} + ((sz == 2'b00) ? 3'd0 : (sz == 2'b01) ? 3'd1 : 3'd3);
    return last[2];
  endfunction

  function automatic logic illegal(input logic [2:0] f3, input logic st);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && st);
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] sz);
    return spans(off, sz) || ((sz == 2'b01) && off[0]) || (sz[1] && (off != 2'b00));
  endfunction
`endif

  // request decode at accept time
  logic bad_in, sw_aligned_in;
  assign bad_in = illegal(bus.req_funct3, bus.req_store)
`ifdef MISALIGN_TRAP_EN
                  || misaligned(bus.req_addr[1:0], bus.req_funct3[1:0])
`endif
                  ;
  assign sw_aligned_in = bus.req_store && (bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] == 2'b00);

  // latched request geometry
  logic [1:0]        off_q;
  logic              span_q;
  logic [ADDR_W-1:0] word0, word1;
  assign off_q  = addr_q[1:0];
  assign span_q = spans(off_q, f3_q[1:0]);
  assign word0  = addr_q[ADDR_W+1:2];
  assign word1  = word0 + ADDR_W'(1);   // wraps past the top word

  // store merge: store bytes shifted to lane off, overlaid on the read pair
  logic [63:0] old_pair, new_pair, merged;
  logic [7:0]  lane_en;
  assign old_pair = {w1_q, w0_q};
  assign new_pair = {32'b0, wdata_q} << {off_q, 3'b000};
  assign lane_en  = {4'b0000, size_mask(f3_q[1:0])} << off_q;

  for (genvar l = 0; l < 8; l++) begin : g_lane
    assign merged[8*l +: 8] = lane_en[l] ? new_pair[8*l +: 8] : old_pair[8*l +: 8];
  end

  // load assembly uses the word arriving this cycle so data is ready on entry to RESP
  logic [31:0] w0_nxt, w1_nxt, rd_word, load_data;
  assign w0_nxt = (state_q == RD0) ? bus.mem_rdata : w0_q;
`ifdef MISALIGN_TRAP_EN
  assign w1_nxt = w1_q;
`else
  assign w1_nxt = (state_q == RD1) ? bus.mem_rdata : w1_q;
`endif
  assign rd_word = 32'({w1_nxt, w0_nxt} >> {off_q, 3'b000});

  // sign/zero extension by funct3
  always_comb begin
    load_data = rd_word;
    case (f3_q)
      3'b000:  load_data = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  load_data = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  load_data = {24'b0, rd_word[7:0]};
      3'b101:  load_data = {16'b0, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and memory/handshake outputs; outputs depend only on state and latched fields
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (bad_in)             state_d = RESP;
          else if (sw_aligned_in) state_d = WR0;
          else                    state_d = RD0;
        end
      end
      RD0: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = word0;
        if (bus.mem_grant) begin
`ifndef MISALIGN_TRAP_EN
          if (span_q)     state_d = RD1;
          else
`endif
          if (!st_q)      state_d = RESP;
          else            state_d = WR0;
        end
      end
`ifndef MISALIGN_TRAP_EN
      RD1: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = word1;
        if (bus.mem_grant) state_d = st_q ? WR0 : RESP;
      end
`endif
      WR0: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = word0;
        bus.mem_wdata = merged[31:0];
        if (bus.mem_grant) begin
`ifndef MISALIGN_TRAP_EN
          if (span_q) state_d = WR1;
          else
`endif
                      state_d = RESP;
        end
      end
`ifndef MISALIGN_TRAP_EN
      WR1: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = word1;
        bus.mem_wdata = merged[63:32];
        if (bus.mem_grant) state_d = RESP;
      end
`endif
      RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // request latch and captured read words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      if (accept) begin
        st_q    <= bus.req_store;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if ((state_q == RD0) && bus.mem_grant) w0_q <= bus.mem_rdata;
`ifndef MISALIGN_TRAP_EN
      if ((state_q == RD1) && bus.mem_grant) w1_q <= bus.mem_rdata;
`endif
    end
  end

  // response data/err: err set at accept, data loaded on entry to RESP and held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (accept) resp_err_q <= bad_in;
      if ((state_d == RESP) && (state_q != RESP))
        resp_data_q <= (accept || st_q) ? 32'b0 : load_data;
    end
  end

  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: word memory model, latency and
// data checks per access, stall, reset abort, illegal funct3, wrap-around.
module tb_lsu_mem_initiator;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              grant = 1'b1;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [31:0]       ld_data = '0;
  logic [31:0]       mem [0:63];
  int                nrd = 0, nwr = 0;
  int                nvec = 0, nerr = 0;

  lsu_mem_initiator_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_mem_initiator #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.mem_grant = grant;
  assign bus.mem_rdata = mem[bus.mem_addr];

  // memory array with preload port, plus granted-access counters
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_write && bus.mem_grant) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read && bus.mem_grant)  nrd <= nrd + 1;
    if (bus.mem_write && bus.mem_grant) nwr <= nwr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a[ADDR_W-1:0]; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // one request; stall > 0 holds grant low for that many cycles after accept
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd, input int stall,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_rd, input int exp_wr);
    int          lat, rd0, wr0;
    logic        seen;
    logic [31:0] a0, r0, got_data;
    logic        got_err;
    @(negedge clk);
    grant = (stall == 0);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = addr;  bus.req_wdata = wd;
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
    rd0 = nrd; wr0 = nwr;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; seen = 1'b0; a0 = '0; r0 = '0; got_data = '0; got_err = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (stall > 0) begin
        if (lat == 1) begin
          a0 = 32'(bus.mem_addr); r0 = 32'(bus.mem_read);
        end else if (lat <= stall + 1) begin
          chk({tag, "/stall_addr"}, 32'(bus.mem_addr), a0);
          chk({tag, "/stall_read"}, 32'(bus.mem_read), r0);
        end
        if (lat == stall + 1) grant = 1'b1;
      end
      if (bus.resp_valid) begin
        seen = 1'b1; got_data = bus.resp_data; got_err = bus.resp_err;
      end
    end
    grant = 1'b1;
    chk({tag, "/lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "/data"}, got_data, exp_data);
    chk({tag, "/err"},  32'(got_err), 32'(exp_err));
    chk({tag, "/reads"},  32'(nrd - rd0), 32'(exp_rd));
    chk({tag, "/writes"}, 32'(nwr - wr0), 32'(exp_wr));
    @(negedge clk);
    chk({tag, "/oneshot"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    int wr_base;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    poke(0, 32'h11223344);
    poke(1, 32'hAABBCCDD);
    poke(2, 32'h00000000);
    poke(63, 32'h000000FF);

    // reset state
    @(negedge clk);
    chk("rst/ready", 32'(bus.req_ready), 32'd1);
    chk("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst/mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst/mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst/mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst/mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst/resp_data", bus.resp_data, 32'd0);
    chk("rst/resp_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b0;

    // aligned and sub-word loads
    do_req("lw0",   1'b0, 3'b010, 8'd0, 32'd0, 0, 2, 32'h11223344, 1'b0, 1, 0);
    do_req("lb7",   1'b0, 3'b000, 8'd7, 32'd0, 0, 2, 32'hFFFFFFAA, 1'b0, 1, 0);
    do_req("lbu7",  1'b0, 3'b100, 8'd7, 32'd0, 0, 2, 32'h000000AA, 1'b0, 1, 0);
    repeat (2) @(negedge clk);
    chk("hold/resp_data", bus.resp_data, 32'h000000AA);
    do_req("lh4",   1'b0, 3'b001, 8'd4, 32'd0, 0, 2, 32'hFFFFCCDD, 1'b0, 1, 0);
    do_req("lb1",   1'b0, 3'b000, 8'd1, 32'd0, 0, 2, 32'h00000033, 1'b0, 1, 0);
    do_req("lhu6",  1'b0, 3'b101, 8'd6, 32'd0, 0, 2, 32'h0000AABB, 1'b0, 1, 0);

    // sub-word store: read-modify-write of word 2
    do_req("sh10",  1'b1, 3'b001, 8'd10, 32'h1234BEEF, 0, 3, 32'd0, 1'b0, 1, 1);
    chk("sh10/mem2", mem[2], 32'hBEEF0000);

    // spanning loads
`ifdef MISALIGN_TRAP_EN
    do_req("lw2",   1'b0, 3'b010, 8'd2, 32'd0, 0, 1, 32'd0, 1'b1, 0, 0);
    do_req("lhu3",  1'b0, 3'b101, 8'd3, 32'd0, 0, 1, 32'd0, 1'b1, 0, 0);
`else
    do_req("lw2",   1'b0, 3'b010, 8'd2, 32'd0, 0, 3, 32'hCCDD1122, 1'b0, 2, 0);
    do_req("lhu3",  1'b0, 3'b101, 8'd3, 32'd0, 0, 3, 32'h0000DD11, 1'b0, 2, 0);
`endif

    // three-cycle grant stall in RD0
    do_req("stall", 1'b0, 3'b010, 8'd4, 32'd0, 3, 5, 32'hAABBCCDD, 1'b0, 1, 0);

    // illegal encodings
    do_req("f3_111", 1'b0, 3'b111, 8'd0, 32'd0, 0, 1, 32'd0, 1'b1, 0, 0);
    do_req("sbu",    1'b1, 3'b100, 8'd0, 32'd0, 0, 1, 32'd0, 1'b1, 0, 0);
    do_req("lw0b",   1'b0, 3'b010, 8'd0, 32'd0, 0, 2, 32'h11223344, 1'b0, 1, 0);

    // reset while WR0 waits for grant: no write, idle at once
    @(negedge clk);
    grant = 1'b0;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 8'd8; bus.req_wdata = 32'hDEADBEEF;
    wr_base = nwr;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort/wr0_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort/ready", 32'(bus.req_ready), 32'd1);
    chk("abort/write", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0; grant = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort/mem2", mem[2], 32'hBEEF0000);
    chk("abort/nwr", 32'(nwr - wr_base), 32'd0);

    // word-crossing store wrapping from word 63 to word 0
`ifdef MISALIGN_TRAP_EN
    do_req("sw254", 1'b1, 3'b010, 8'd254, 32'hA1B2C3D4, 0, 1, 32'd0, 1'b1, 0, 0);
    chk("sw254/mem63", mem[63], 32'h000000FF);
    chk("sw254/mem0",  mem[0],  32'h11223344);
`else
    do_req("sw254", 1'b1, 3'b010, 8'd254, 32'hA1B2C3D4, 0, 5, 32'd0, 1'b0, 2, 2);
    chk("sw254/mem63", mem[63], 32'hC3D400FF);
    chk("sw254/mem0",  mem[0],  32'h1122A1B2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
